// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the M-stage core port and an external requester.
// Optional: define DMEM_ARB_PERF_EN to add perf_stall_cnt / perf_ext_cnt counters.
`default_nettype none

module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_ext_cnt
`endif
);

  localparam logic [0:0] C_IDLE  = 1'b0;
  localparam logic [0:0] C_RDATA = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [0:0] state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [1:0] owner_q, owner_d;

  logic core_elig, ext_elig, core_win, ext_win;

  // Inputs are gated with rst so every output is 0 while reset is held.
  always_comb begin
    core_elig = rst && (state_q == C_IDLE) && core_req;
    ext_elig  = rst && ext_req;
    ext_win   = ext_elig && (!core_elig || (starve_q == STARVE_LIM));
    core_win  = core_elig && !ext_win;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ext_win) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (core_win) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  assign ext_gnt    = ext_win;
  assign core_stall = core_elig && !(core_win && core_we);
  assign core_rdata = (rst && (state_q == C_RDATA)) ? mem_rdata : '0;
  assign ext_rvalid = rst && (owner_q == OWN_EXT);
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

  always_comb begin
    state_d  = C_IDLE;
    owner_d  = OWN_NONE;
    starve_d = starve_q;
    if (core_win && !core_we) begin
      state_d = C_RDATA;
      owner_d = OWN_CORE;
    end else if (ext_win && !ext_we) begin
      owner_d = OWN_EXT;
    end
    // A dropped ext_req keeps the count; only a grant clears it.
    if (ext_win) begin
      starve_d = 4'd0;
    end else if (ext_elig && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= C_IDLE;
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_ext_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_ext_q   <= 32'd0;
    end else begin
      if (core_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (ext_win)    perf_ext_q   <= perf_ext_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_ext_cnt   = perf_ext_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a rule-level model predicts grants and read data; a monitor checks returns.
`default_nettype none

module tb_dmem_arbiter;

  localparam int SM = 4;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_vec_c = 0, n_err_c = 0;
  int n_vec_m = 0, n_err_m = 0;
  int n_vec_i = 0, n_err_i = 0;

  function automatic bit mis(string nm, logic [31:0] a, logic [31:0] e);
    if (a !== e) begin
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  `define CHK_C(nm, a, x) begin n_vec_c++; if (mis(nm, 32'(a), 32'(x))) n_err_c++; end
  `define CHK_M(nm, a, x) begin n_vec_m++; if (mis(nm, 32'(a), 32'(x))) n_err_m++; end
  `define CHK_I(nm, a, x) begin n_vec_i++; if (mis(nm, 32'(a), 32'(x))) n_err_i++; end

  function automatic logic [31:0] initv(int i);
    return 32'hA5C3_0000 | 32'(i);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: the access seen during a cycle is applied at the closing edge.
  logic [31:0] ram [16];
  logic        s_en, s_we;
  logic [31:0] s_addr, s_wdata;
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = initv(i);
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
      @(posedge clk);
      if (s_en) begin
        if (s_we) ram[s_addr[5:2]] = s_wdata;
        else      mem_rdata <= ram[s_addr[5:2]];
      end
    end
  end

  // Reference model: arbitration rules plus an abstract memory image.
  logic [31:0] ref_mem [16];
  logic [31:0] ext_q[$];
  logic [31:0] core_q[$];
  bit          ref_init = 1'b0;
  bit          m_loading, m_ext_rv;
  int          m_wait;

  always @(negedge clk) begin
    bit ce, ew, cw;
    if (!ref_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = initv(i);
      ref_init = 1'b1;
    end
    if (!rst) begin
      `CHK_C("rst_mem_en", mem_en, 0)
      `CHK_C("rst_mem_we", mem_we, 0)
      `CHK_C("rst_mem_addr", mem_addr, 0)
      `CHK_C("rst_mem_wdata", mem_wdata, 0)
      `CHK_C("rst_ext_gnt", ext_gnt, 0)
      `CHK_C("rst_ext_rvalid", ext_rvalid, 0)
      `CHK_C("rst_ext_rdata", ext_rdata, 0)
      `CHK_C("rst_core_stall", core_stall, 0)
      `CHK_C("rst_core_rdata", core_rdata, 0)
      m_loading = 1'b0; m_ext_rv = 1'b0; m_wait = 0;
      ext_q.delete(); core_q.delete();
    end else begin
      ce = !m_loading && core_req;
      ew = ext_req && (!ce || m_wait == SM);
      cw = ce && !ew;
      `CHK_C("ext_gnt", ext_gnt, ew)
      `CHK_C("mem_en", mem_en, ew || cw)
      `CHK_C("mem_we", mem_we, ew ? ext_we : (cw ? core_we : 1'b0))
      `CHK_C("mem_addr", mem_addr, ew ? ext_addr : (cw ? core_addr : 32'd0))
      `CHK_C("mem_wdata", mem_wdata, ew ? ext_wdata : (cw ? core_wdata : 32'd0))
      `CHK_C("core_stall", core_stall, ce && !(cw && core_we))
      `CHK_C("ext_rvalid", ext_rvalid, m_ext_rv)
      if (ew) begin
        if (ext_we) ref_mem[ext_addr[5:2]] = ext_wdata;
        else        ext_q.push_back(ref_mem[ext_addr[5:2]]);
      end
      if (cw) begin
        if (core_we) ref_mem[core_addr[5:2]] = core_wdata;
        else         core_q.push_back(ref_mem[core_addr[5:2]]);
      end
      m_ext_rv  = ew && !ext_we;
      m_wait    = ew ? 0 : (ext_req ? ((m_wait < SM) ? m_wait + 1 : SM) : m_wait);
      m_loading = cw && !core_we;
    end
  end

  // Monitor: ext data on ext_rvalid; core data when a stalled load releases its stall.
  bit pend_load;
  always @(negedge clk) begin
    if (!rst) begin
      pend_load = 1'b0;
    end else begin
      if (ext_rvalid) begin
        if (ext_q.size() == 0) begin
          n_vec_m++; n_err_m++;
          $display("FAIL ext_rdata: got %h expected nothing outstanding", ext_rdata);
        end else `CHK_M("ext_rdata", ext_rdata, ext_q.pop_front())
      end else `CHK_M("ext_rdata_idle", ext_rdata, 0)
      if (pend_load && !core_stall) begin
        if (core_q.size() == 0) begin
          n_vec_m++; n_err_m++;
          $display("FAIL core_rdata: got %h expected nothing outstanding", core_rdata);
        end else `CHK_M("core_rdata", core_rdata, core_q.pop_front())
      end
      pend_load = core_stall && core_req && !core_we;
    end
  end

  task automatic core_op(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit s = 1'b1;
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    for (int i = 0; i < 20 && s; i++) begin
      @(negedge clk); s = core_stall;
      @(posedge clk); #1;
    end
    `CHK_I("core_op_timeout", s, 0)
    core_req = 1'b0;
  endtask

  task automatic ext_op(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit g = 1'b0;
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk); g = ext_gnt;
      @(posedge clk); #1;
    end
    `CHK_I("ext_op_timeout", g, 1)
    ext_req = 1'b0;
  endtask

  task automatic idle(input int n);
    core_req = 1'b0; ext_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_rand(input int n, input int pc, input int pe, input int pw);
    bit hc, he;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); hc = core_stall; he = ext_req && !ext_gnt;
      @(posedge clk); #1;
      if (!hc) begin
        core_req   = ($urandom_range(0, 99) < pc);
        core_we    = ($urandom_range(0, 99) < pw);
        core_addr  = $urandom_range(0, 63);
        core_wdata = $urandom;
      end
      if (!he) begin
        ext_req   = ($urandom_range(0, 99) < pe);
        ext_we    = $urandom_range(0, 1) == 1;
        ext_addr  = $urandom_range(0, 63);
        ext_wdata = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    core_op(1'b1, 32'h10, 32'hDEADBEEF);
    core_op(1'b0, 32'h10, 32'h0);
    ext_op(1'b0, 32'h20, 32'h0);
    idle(2);

    // Core store stream against a held ext request exercises the starvation limit.
    run_rand(14, 100, 100, 100);
    idle(2);
    run_rand(14, 100, 100, 0);
    idle(2);

    // Reset asserted in the load's data cycle.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    @(posedge clk); #1;
    rst = 1'b0; core_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    core_op(1'b0, 32'h10, 32'h0);
    idle(1);

    run_rand(1500, 60, 40, 50);
    idle(4);
    `CHK_I("ext_q_drain", ext_q.size(), 0)
    `CHK_I("core_q_drain", core_q.size(), 0)

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec_c + n_vec_m + n_vec_i, n_err_c + n_err_m + n_err_i);
    $finish;
  end

  `undef CHK_C
  `undef CHK_M
  `undef CHK_I

endmodule

`default_nettype wire
